// File: rtl/iomem_pkg.sv
// Shared types and helpers for the iomem bus fabric (iomem_interconnect, iomem_watchdog).
package iomem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } iomem_state_t;

    localparam logic [31:0] IOMEM_ERR_RDATA = 32'hDEAD_BEEF;

    // Ceiling log2 clamped to at least 1 so single-entry indices still get a bit.
    function automatic int clog2(input int n);
        int w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/iomem_watchdog.sv
// Saturating ACCESS-cycle counter; expired marks the last permitted cycle of an access.
module iomem_watchdog
    import iomem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= '0;
        else if (enable && count != CNT_W'(TIMEOUT_CYCLES))
            count <= count + CNT_W'(1);
    end

    // count holds the number of completed ACCESS cycles, so the TIMEOUT_CYCLES-th cycle is the last one.
    assign expired = (TIMEOUT_CYCLES != 0) && enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/iomem_interconnect.sv
// iomem fabric: slot decode, registered per-slave valid, rdata mux, timeout-guarded completion.
// Optional sticky error interrupt and status/clear register enabled by `IOMEM_ERR_IRQ_EN.
module iomem_interconnect
    import iomem_pkg::*;
#(
    parameter int          NUM_SLAVES     = 8,
    parameter int          BASE_SHIFT     = 24,
    parameter int          SLOT_BASE      = 'h03,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = IOMEM_ERR_RDATA
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     m_valid,
    output logic                     m_ready,
    input  logic [31:0]              m_addr,
    input  logic [31:0]              m_wdata,
    input  logic [3:0]               m_wstrb,
    output logic [31:0]              m_rdata,
    output logic [NUM_SLAVES-1:0]    s_valid,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    output logic [3:0]               s_wstrb,
    input  logic [NUM_SLAVES-1:0]    s_ready,
    input  logic [32*NUM_SLAVES-1:0] s_rdata,
    output logic                     err_irq
);
    localparam int FIELD_W = 32 - BASE_SHIFT;
    localparam int SLOT_W  = clog2(NUM_SLAVES);

    iomem_state_t      state;
    logic [SLOT_W-1:0] slot;
    logic [FIELD_W-1:0] field;
    logic [FIELD_W:0]  field_off;
    logic              mapped;
    logic              sel_ready;
    logic [31:0]       sel_rdata;
    logic              wd_expired;

    assign s_addr  = m_addr;
    assign s_wdata = m_wdata;
    assign s_wstrb = m_wstrb;

    // One extra bit makes addresses below SLOT_BASE wrap to large values and fail the range test.
    assign field     = m_addr[31:BASE_SHIFT];
    assign field_off = {1'b0, field} - (FIELD_W + 1)'(SLOT_BASE);
    assign mapped    = field_off < (FIELD_W + 1)'(NUM_SLAVES);
    assign sel_ready = s_ready[slot];
    assign sel_rdata = s_rdata[32*slot +: 32];

    iomem_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .load   (state != ST_ACCESS),
        .enable (state == ST_ACCESS),
        .expired(wd_expired)
    );

`ifdef IOMEM_ERR_IRQ_EN
    logic decode_seen;
    logic timeout_seen;
    logic csr_hit;

    assign csr_hit = {1'b0, field} == (FIELD_W + 1)'(SLOT_BASE + NUM_SLAVES);
    assign err_irq = decode_seen | timeout_seen;
`else
    assign err_irq = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            m_ready <= 1'b0;
            m_rdata <= '0;
            s_valid <= '0;
            slot    <= '0;
`ifdef IOMEM_ERR_IRQ_EN
            decode_seen  <= 1'b0;
            timeout_seen <= 1'b0;
`endif
        end else begin
            m_ready <= 1'b0;
            case (state)
                // The master still holds m_valid during the m_ready cycle; that must not start a new access.
                ST_IDLE: begin
                    if (m_valid && !m_ready) begin
                        if (mapped) begin
                            slot    <= field_off[SLOT_W-1:0];
                            s_valid <= NUM_SLAVES'(1) << field_off[SLOT_W-1:0];
                            state   <= ST_ACCESS;
                        end
`ifdef IOMEM_ERR_IRQ_EN
                        else if (csr_hit) begin
                            m_rdata <= {30'b0, timeout_seen, decode_seen};
                            if (|m_wstrb) begin
                                decode_seen  <= 1'b0;
                                timeout_seen <= 1'b0;
                            end
                            state <= ST_RESP;
                        end
`endif
                        else begin
                            m_rdata <= ERR_RDATA;
                            state   <= ST_RESP;
`ifdef IOMEM_ERR_IRQ_EN
                            decode_seen <= 1'b1;
`endif
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!m_valid) begin
                        s_valid <= '0;
                        state   <= ST_IDLE;
                    end else if (sel_ready) begin
                        m_rdata <= sel_rdata;
                        s_valid <= '0;
                        state   <= ST_RESP;
                    end else if (wd_expired) begin
                        m_rdata <= ERR_RDATA;
                        s_valid <= '0;
                        state   <= ST_RESP;
`ifdef IOMEM_ERR_IRQ_EN
                        timeout_seen <= 1'b1;
`endif
                    end
                end
                ST_RESP: begin
                    m_ready <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iomem_interconnect.sv
// Directed bench for iomem_interconnect: vector table plus abort, reset and error-register sequences.
module tb_iomem_interconnect;

    localparam int NS = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              m_valid;
    logic              m_ready;
    logic [31:0]       m_addr;
    logic [31:0]       m_wdata;
    logic [3:0]        m_wstrb;
    logic [31:0]       m_rdata;
    logic [NS-1:0]     s_valid;
    logic [31:0]       s_addr;
    logic [31:0]       s_wdata;
    logic [3:0]        s_wstrb;
    logic [NS-1:0]     s_ready;
    logic [32*NS-1:0]  s_rdata;
    logic              err_irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          slot;
        int          delay;
        int          stray;
        logic [31:0] srdata;
        int          exp_lat;
        logic [31:0] exp_rd;
        logic [7:0]  exp_sel;
    } vec_t;

    vec_t vecs[8];

    iomem_interconnect #(
        .NUM_SLAVES    (NS),
        .BASE_SHIFT    (24),
        .SLOT_BASE     ('h03),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_addr (m_addr),
        .m_wdata(m_wdata),
        .m_wstrb(m_wstrb),
        .m_rdata(m_rdata),
        .s_valid(s_valid),
        .s_addr (s_addr),
        .s_wdata(s_wdata),
        .s_wstrb(s_wstrb),
        .s_ready(s_ready),
        .s_rdata(s_rdata),
        .err_irq(err_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drives one master transaction and models the addressed slave; cycle 0 is the m_valid cycle.
    task automatic run_txn(input vec_t v, input string name);
        int          lat, pulses, vcnt, late_sv;
        logic [31:0] rd;
        logic [7:0]  seen;
        bit          sv_low, bcast_ok;
        lat = -1; pulses = 0; vcnt = 0; late_sv = 0;
        rd = '0; seen = '0; sv_low = 1'b0; bcast_ok = 1'b1;
        @(negedge clk);
        m_valid = 1'b1;
        m_addr  = v.addr;
        m_wdata = v.wdata;
        m_wstrb = v.wstrb;
        s_ready = '0;
        for (int i = 0; i < NS; i++) s_rdata[32*i +: 32] = 32'hA000_0000 | 32'(i);
        s_rdata[32*v.slot +: 32] = v.srdata;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            seen |= s_valid;
            if (s_addr !== m_addr || s_wdata !== m_wdata || s_wstrb !== m_wstrb) bcast_ok = 1'b0;
            if (lat >= 0 && s_valid != '0) late_sv++;
            if (m_ready === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat    = c;
                    rd     = m_rdata;
                    sv_low = (s_valid == '0);
                end
            end
            if (lat >= 0 && c == lat + 1) m_valid = 1'b0;
            s_ready = '0;
            if (s_valid != '0 && m_valid) begin
                if (vcnt == v.delay) s_ready[v.slot] = 1'b1;
                else if (v.stray >= 0 && vcnt < v.delay) s_ready[v.stray] = 1'b1;
                vcnt++;
            end
            if (lat >= 0 && c >= lat + 4) break;
        end
        m_valid = 1'b0;
        s_ready = '0;
        chk({name, ".latency"}, 32'(lat), 32'(v.exp_lat));
        chk({name, ".rdata"}, rd, v.exp_rd);
        chk({name, ".s_valid_seen"}, 32'(seen), 32'(v.exp_sel));
        chk({name, ".ready_pulses"}, 32'(pulses), 32'd1);
        chk({name, ".s_valid_low_at_ready"}, 32'(sv_low), 32'd1);
        chk({name, ".broadcast"}, 32'(bcast_ok), 32'd1);
        chk({name, ".no_late_s_valid"}, 32'(late_sv), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vec_t        v;
        int          pulses;
        logic [31:0] exp_csr;

        //              addr          wdata         wstrb slot dly stray srdata        lat exp_rd        sel
        vecs[0] = '{32'h0500_0000, 32'h0,         4'h0, 2,  0, -1, 32'h1234_5678, 3,  32'h1234_5678, 8'h04};
        vecs[1] = '{32'h0300_0004, 32'hCAFE_F00D, 4'hF, 0,  5, -1, 32'h0,         8,  32'h0,         8'h01};
        vecs[2] = '{32'h0F00_0000, 32'h0,         4'h0, 0,  0, -1, 32'h5555_5555, 2,  32'hDEAD_BEEF, 8'h00};
        vecs[3] = '{32'h0200_0010, 32'h0,         4'h0, 0,  0, -1, 32'h5555_5555, 2,  32'hDEAD_BEEF, 8'h00};
        vecs[4] = '{32'h0A00_0000, 32'h0,         4'h0, 7,  1, -1, 32'h7777_0007, 4,  32'h7777_0007, 8'h80};
        vecs[5] = '{32'h0400_0000, 32'h0,         4'h0, 1,  3,  3, 32'h1111_1111, 6,  32'h1111_1111, 8'h02};
        vecs[6] = '{32'h0600_0000, 32'h0,         4'h0, 3, -1, -1, 32'h3333_3333, 18, 32'hDEAD_BEEF, 8'h08};
        vecs[7] = '{32'h0700_0000, 32'h0000_00AB, 4'h1, 4, 15, -1, 32'h4444_4444, 18, 32'h4444_4444, 8'h10};

        reset = 1'b1; m_valid = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        s_ready = '0; s_rdata = '0;
        repeat (2) @(negedge clk);
        chk("reset.m_ready", 32'(m_ready), 32'd0);
        chk("reset.m_rdata", m_rdata, 32'd0);
        chk("reset.s_valid", 32'(s_valid), 32'd0);
        chk("reset.err_irq", 32'(err_irq), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Error status register at SLOT_BASE+NUM_SLAVES.
`ifdef IOMEM_ERR_IRQ_EN
        exp_csr = 32'h0000_0003;
        chk("irq_after_errors", 32'(err_irq), 32'd1);
`else
        exp_csr = 32'hDEAD_BEEF;
        chk("irq_after_errors", 32'(err_irq), 32'd0);
`endif
        v = '{32'h0B00_0000, 32'h0, 4'h0, 0, 0, -1, 32'h6666_6666, 2, exp_csr, 8'h00};
        run_txn(v, "csr_read");
`ifdef IOMEM_ERR_IRQ_EN
        chk("irq_after_read", 32'(err_irq), 32'd1);
`else
        chk("irq_after_read", 32'(err_irq), 32'd0);
`endif
        v = '{32'h0B00_0000, 32'h0, 4'hF, 0, 0, -1, 32'h6666_6666, 2, exp_csr, 8'h00};
        run_txn(v, "csr_write");
        chk("irq_after_clear", 32'(err_irq), 32'd0);

        // Master drops m_valid mid-access: fabric returns to idle without completing.
        @(negedge clk);
        m_valid = 1'b1; m_addr = 32'h0800_0000; m_wstrb = 4'h0;
        @(negedge clk);
        chk("abort.s_valid_active", 32'(s_valid), 32'h20);
        repeat (2) @(negedge clk);
        m_valid = 1'b0;
        @(negedge clk);
        chk("abort.s_valid_dropped", 32'(s_valid), 32'd0);
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (m_ready === 1'b1) pulses++;
        end
        chk("abort.no_ready", 32'(pulses), 32'd0);

        // Asynchronous reset in the middle of an access.
        @(negedge clk);
        m_valid = 1'b1; m_addr = 32'h0300_0000;
        repeat (3) @(negedge clk);
        chk("rst_mid.s_valid_before", 32'(s_valid), 32'h01);
        reset = 1'b1;
        #1;
        chk("rst_mid.s_valid", 32'(s_valid), 32'd0);
        chk("rst_mid.m_ready", 32'(m_ready), 32'd0);
        chk("rst_mid.m_rdata", m_rdata, 32'd0);
        chk("rst_mid.err_irq", 32'(err_irq), 32'd0);
        m_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid.m_rdata_held", m_rdata, 32'd0);
        reset = 1'b0;
        v = '{32'h0300_0000, 32'h0, 4'h0, 0, 0, -1, 32'h0BAD_CAFE, 3, 32'h0BAD_CAFE, 8'h01};
        run_txn(v, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
